// File: rtl/dbg_bus_master.sv
// Debug bus initiator: parses CMD/ADDR/DATA byte frames into single 32-bit
// sel/we/ready bus transactions and returns ack, read data or error bytes.
//
// state | meaning
// IDLE  | waiting for a command byte
// ADDR  | collecting 4 address bytes, LSB first
// DATA  | collecting 4 write-data bytes, LSB first
// BUS   | bus_sel held until bus_ready or timeout
// RESP  | streaming response byte(s) out on tx
module dbg_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [7:0]  ACK_BYTE       = 8'hA5,
  parameter logic [7:0]  ERR_TIMEOUT    = 8'hEE,
  parameter logic [7:0]  ERR_CMD        = 8'hEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_sel,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  state_t        r_state,     w_state;
  logic [1:0]    r_byte_cnt,  w_byte_cnt;
  logic          r_we,        w_we;
  logic [31:0]   r_addr,      w_addr;
  logic [31:0]   r_wdata,     w_wdata;
  logic          r_sel,       w_sel;
  logic [TW-1:0] r_tmo,       w_tmo;
  logic [7:0]    r_tx_data,   w_tx_data;
  logic          r_tx_valid,  w_tx_valid;
  logic [23:0]   r_resp_buf,  w_resp_buf;
  logic [1:0]    r_resp_left, w_resp_left;
  logic          r_rx_ready,  w_rx_ready;
  logic          r_busy,      w_busy;

  logic          w_rx_acc;
  logic          w_tx_acc;
  logic [TW-1:0] w_tmo_inc;

  assign w_rx_acc  = rx_valid && r_rx_ready;
  assign w_tx_acc  = r_tx_valid && tx_ready;
  assign w_tmo_inc = r_tmo + TW'(1);

  always_comb begin
    w_state     = r_state;
    w_byte_cnt  = r_byte_cnt;
    w_we        = r_we;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_sel       = r_sel;
    w_tmo       = r_tmo;
    w_tx_data   = r_tx_data;
    w_tx_valid  = r_tx_valid;
    w_resp_buf  = r_resp_buf;
    w_resp_left = r_resp_left;

    case (r_state)
      S_IDLE: begin
        if (w_rx_acc) begin
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            w_state    = S_ADDR;
            w_we       = (rx_data == CMD_WR);
            w_byte_cnt = 2'd0;
          end else begin
            w_state     = S_RESP;
            w_tx_valid  = 1'b1;
            w_tx_data   = ERR_CMD;
            w_resp_left = 2'd0;
          end
        end
      end
      S_ADDR: begin
        if (w_rx_acc) begin
          w_addr[{r_byte_cnt, 3'b000} +: 8] = rx_data;
          w_byte_cnt = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            if (r_we) begin
              w_state    = S_DATA;
              w_byte_cnt = 2'd0;
            end else begin
              w_state = S_BUS;
              w_sel   = 1'b1;
              w_tmo   = '0;
            end
          end
        end
      end
      S_DATA: begin
        if (w_rx_acc) begin
          w_wdata[{r_byte_cnt, 3'b000} +: 8] = rx_data;
          w_byte_cnt = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            w_state = S_BUS;
            w_sel   = 1'b1;
            w_tmo   = '0;
          end
        end
      end
      S_BUS: begin
        // A ready in the last allowed cycle wins over the timeout.
        if (bus_ready) begin
          w_state     = S_RESP;
          w_sel       = 1'b0;
          w_tx_valid  = 1'b1;
          w_tx_data   = r_we ? ACK_BYTE : bus_rdata[7:0];
          w_resp_buf  = bus_rdata[31:8];
          w_resp_left = r_we ? 2'd0 : 2'd3;
        end else if (w_tmo_inc == TMO_LAST) begin
          w_state     = S_RESP;
          w_sel       = 1'b0;
          w_tx_valid  = 1'b1;
          w_tx_data   = ERR_TIMEOUT;
          w_resp_left = 2'd0;
        end else begin
          w_tmo = w_tmo_inc;
        end
      end
      S_RESP: begin
        if (w_tx_acc) begin
          if (r_resp_left == 2'd0) begin
            w_state    = S_IDLE;
            w_tx_valid = 1'b0;
          end else begin
            w_tx_data   = r_resp_buf[7:0];
            w_resp_buf  = {8'h00, r_resp_buf[23:8]};
            w_resp_left = r_resp_left - 2'd1;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase

    w_rx_ready = (w_state == S_IDLE) || (w_state == S_ADDR) || (w_state == S_DATA);
    w_busy     = (w_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_byte_cnt  <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_sel       <= 1'b0;
      r_tmo       <= '0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_resp_buf  <= '0;
      r_resp_left <= '0;
      r_rx_ready  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_byte_cnt  <= w_byte_cnt;
      r_we        <= w_we;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_sel       <= w_sel;
      r_tmo       <= w_tmo;
      r_tx_data   <= w_tx_data;
      r_tx_valid  <= w_tx_valid;
      r_resp_buf  <= w_resp_buf;
      r_resp_left <= w_resp_left;
      r_rx_ready  <= w_rx_ready;
      r_busy      <= w_busy;
    end
  end

  assign rx_ready  = r_rx_ready;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign bus_sel   = r_sel;
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_dbg_bus_master.sv
// Bench for dbg_bus_master: scenario tasks plus randomized frames checked
// against a frame-level model of expected bus activity and response bytes.
module tb_dbg_bus_master;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_sel;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        busy;

  always #5 clk = ~clk;

  dbg_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_sel(bus_sel), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  fb[9];
  int          flen;
  int          o_sel_cycles;
  logic        o_we;
  logic [31:0] o_addr, o_wdata;
  bit          o_bus_stable, o_tx_stable, o_rx_blocked, o_idle_after;
  int          o_lat;
  logic [7:0]  o_tx[$];
  int          m_sel;
  logic [7:0]  m_tx[$];

  task automatic build(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data);
    fb[0] = cmd;
    for (int i = 0; i < 4; i++) begin
      fb[1+i] = addr[8*i +: 8];
      fb[5+i] = data[8*i +: 8];
    end
    flen = (cmd == 8'h01) ? 9 : (cmd == 8'h02) ? 5 : 1;
  endtask

  // Frame-level reference: bus cycles with sel high and the response bytes.
  task automatic model(input logic [7:0] cmd, input logic [31:0] rdata, input int wait_n);
    m_tx.delete();
    if (cmd != 8'h01 && cmd != 8'h02) begin
      m_sel = 0;
      m_tx.push_back(8'hEF);
    end else if (wait_n < 0 || wait_n >= TMO) begin
      m_sel = TMO;
      m_tx.push_back(8'hEE);
    end else begin
      m_sel = wait_n + 1;
      if (cmd == 8'h01) m_tx.push_back(8'hA5);
      else for (int i = 0; i < 4; i++) m_tx.push_back(rdata[8*i +: 8]);
    end
  endtask

  // Drives fb[0..flen-1], plays the responder (ready after wait_n sel cycles,
  // -1 = never) and the tx sink (stalls first stall_n valid cycles).
  task automatic run_frame(input int exp_tx, input int wait_n, input logic [31:0] rdata, input int stall_n);
    int idx = 0, cyc = 0, stall = 0, last_sel = -1, first_tx = -1;
    logic [7:0] prev = 8'h00;
    bit prev_v = 0, rx_acc;
    o_sel_cycles = 0; o_we = 0; o_addr = 0; o_wdata = 0;
    o_bus_stable = 1; o_tx_stable = 1; o_rx_blocked = 1; o_lat = -1;
    o_tx.delete();
    while (o_tx.size() < exp_tx && cyc < 600) begin
      @(negedge clk);
      rx_valid  = (idx < flen);
      rx_data   = (idx < flen) ? fb[idx] : 8'h00;
      rx_acc    = rx_valid && rx_ready;
      bus_ready = 1'b0;
      bus_rdata = $urandom;
      if (bus_sel) begin
        if (o_sel_cycles == 0) begin
          o_we = bus_we; o_addr = bus_addr; o_wdata = bus_wdata;
        end else if (bus_we !== o_we || bus_addr !== o_addr || (o_we && bus_wdata !== o_wdata)) begin
          o_bus_stable = 0;
        end
        if (wait_n >= 0 && o_sel_cycles == wait_n) begin
          bus_ready = 1'b1;
          bus_rdata = rdata;
        end
        o_sel_cycles++;
        last_sel = cyc;
      end
      tx_ready = 1'b0;
      if (tx_valid) begin
        if (first_tx < 0) first_tx = cyc;
        if (prev_v && tx_data !== prev) o_tx_stable = 0;
        if (stall < stall_n) begin
          stall++;
          if (rx_ready !== 1'b0) o_rx_blocked = 0;
          prev = tx_data;
          prev_v = 1;
        end else begin
          tx_ready = 1'b1;
          o_tx.push_back(tx_data);
          prev_v = 0;
        end
      end
      @(posedge clk);
      if (rx_acc) idx++;
      cyc++;
    end
    if (cyc >= 600) begin
      errors++;
      $display("FAIL frame_timeout got %0d bytes exp %0d", o_tx.size(), exp_tx);
    end
    @(negedge clk);
    o_idle_after = (busy === 1'b0) && (rx_ready === 1'b1) && (tx_valid === 1'b0);
    rx_valid = 0; tx_ready = 0; bus_ready = 0;
    if (last_sel >= 0 && first_tx >= 0) o_lat = first_tx - last_sel;
  endtask

  task automatic push_bytes(input int n);
    int idx = 0, cyc = 0;
    bit acc;
    while (idx < n && cyc < 50) begin
      @(negedge clk);
      rx_valid = 1; rx_data = fb[idx];
      acc = rx_ready;
      @(posedge clk);
      if (acc) idx++;
      cyc++;
    end
    if (idx < n) begin
      errors++;
      $display("FAIL push_bytes got %0d exp %0d", idx, n);
    end
  endtask

  task automatic test_reset();
    reset = 1; rx_valid = 0; rx_data = 0; tx_ready = 0; bus_ready = 0; bus_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tx_valid, tx_data, bus_sel, bus_we, bus_addr, bus_wdata, busy, rx_ready} !== 77'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {tx_valid, tx_data, bus_sel, bus_we, bus_addr, bus_wdata, busy, rx_ready});
    end
    reset = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rx_ready=%b busy=%b exp 1 0", rx_ready, busy);
    end
  endtask

  task automatic test_write();
    build(8'h01, 32'h10, 32'h2A); model(8'h01, 32'h0, 0);
    run_frame(m_tx.size(), 0, 32'h0, 0);
    checks++;
    if (o_sel_cycles !== 1 || o_we !== 1'b1) begin
      errors++; $display("FAIL write_sel got cycles=%0d we=%b exp 1 1", o_sel_cycles, o_we);
    end
    checks++;
    if (o_addr !== 32'h10 || o_wdata !== 32'h2A) begin
      errors++; $display("FAIL write_addr_data got %h %h exp 10 2a", o_addr, o_wdata);
    end
    checks++;
    if (o_tx.size() != 1 || o_tx[0] !== 8'hA5) begin
      errors++; $display("FAIL write_ack got %0d bytes first %h exp a5", o_tx.size(), (o_tx.size() > 0) ? o_tx[0] : 8'h00);
    end
    checks++;
    if (o_lat !== 1 || !o_idle_after) begin
      errors++; $display("FAIL write_timing got lat=%0d idle=%0d exp 1 1", o_lat, o_idle_after);
    end
  endtask

  task automatic test_read_wait();
    build(8'h02, 32'h10, 32'h0); model(8'h02, 32'h2A, 3);
    run_frame(m_tx.size(), 3, 32'h2A, 0);
    checks++;
    if (o_sel_cycles !== 4 || o_we !== 1'b0 || o_addr !== 32'h10 || !o_bus_stable) begin
      errors++; $display("FAIL read_bus got cycles=%0d we=%b addr=%h stable=%0d exp 4 0 10 1", o_sel_cycles, o_we, o_addr, o_bus_stable);
    end
    checks++;
    if (o_tx.size() != 4) begin
      errors++; $display("FAIL read_len got %0d exp 4", o_tx.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (o_tx[i] !== m_tx[i]) begin
          errors++; $display("FAIL read_byte%0d got %h exp %h", i, o_tx[i], m_tx[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    build(8'h02, 32'h80, 32'h0); model(8'h02, 32'h0, -1);
    run_frame(m_tx.size(), -1, 32'h0, 0);
    checks++;
    if (o_sel_cycles !== TMO) begin
      errors++; $display("FAIL timeout_sel got %0d exp %0d", o_sel_cycles, TMO);
    end
    checks++;
    if (o_tx.size() != 1 || o_tx[0] !== 8'hEE || !o_idle_after) begin
      errors++; $display("FAIL timeout_resp got %0d bytes first %h idle=%0d exp ee 1", o_tx.size(), (o_tx.size() > 0) ? o_tx[0] : 8'h00, o_idle_after);
    end
    build(8'h01, 32'h84, 32'hCAFE0001); model(8'h01, 32'h0, TMO - 1);
    run_frame(m_tx.size(), TMO - 1, 32'h0, 0);
    checks++;
    if (o_sel_cycles !== TMO || o_tx.size() != 1 || o_tx[0] !== 8'hA5) begin
      errors++; $display("FAIL last_cycle_ready got cycles=%0d first %h exp %0d a5", o_sel_cycles, (o_tx.size() > 0) ? o_tx[0] : 8'h00, TMO);
    end
  endtask

  task automatic test_bad_cmd();
    build(8'h7F, 32'h0, 32'h0); model(8'h7F, 32'h0, 0);
    run_frame(m_tx.size(), 0, 32'h0, 0);
    checks++;
    if (o_sel_cycles !== 0 || o_tx.size() != 1 || o_tx[0] !== 8'hEF || !o_idle_after) begin
      errors++; $display("FAIL bad_cmd got sel=%0d first %h idle=%0d exp 0 ef 1", o_sel_cycles, (o_tx.size() > 0) ? o_tx[0] : 8'h00, o_idle_after);
    end
    build(8'h01, 32'h10, 32'h2A); model(8'h01, 32'h0, 0);
    run_frame(m_tx.size(), 0, 32'h0, 0);
    checks++;
    if (o_sel_cycles !== 1 || o_addr !== 32'h10 || o_wdata !== 32'h2A || o_tx.size() != 1 || o_tx[0] !== 8'hA5) begin
      errors++; $display("FAIL after_bad_cmd got sel=%0d addr=%h wdata=%h exp 1 10 2a", o_sel_cycles, o_addr, o_wdata);
    end
  endtask

  task automatic test_tx_stall();
    build(8'h02, 32'h20, 32'h0); model(8'h02, 32'hDEADBEEF, 1);
    run_frame(m_tx.size(), 1, 32'hDEADBEEF, 10);
    checks++;
    if (!o_tx_stable || !o_rx_blocked) begin
      errors++; $display("FAIL stall_hold got stable=%0d rx_blocked=%0d exp 1 1", o_tx_stable, o_rx_blocked);
    end
    checks++;
    if (o_tx.size() != 4 || o_tx[0] !== 8'hEF || o_tx[1] !== 8'hBE || o_tx[2] !== 8'hAD || o_tx[3] !== 8'hDE) begin
      errors++; $display("FAIL stall_bytes got %0d bytes exp ef be ad de", o_tx.size());
    end
  endtask

  task automatic test_reset_mid();
    build(8'h01, 32'h11223344, 32'h55667788);
    push_bytes(4);
    @(negedge clk); rx_valid = 0; reset = 1;
    @(negedge clk);
    checks++;
    if ({tx_valid, tx_data, bus_sel, bus_we, bus_addr, bus_wdata, busy, rx_ready} !== 77'h0) begin
      errors++; $display("FAIL reset_mid_frame got %h exp 0", {tx_valid, tx_data, bus_sel, bus_we, bus_addr, bus_wdata, busy, rx_ready});
    end
    reset = 0;
    push_bytes(9);
    @(negedge clk); rx_valid = 0;
    checks++;
    if (bus_sel !== 1'b1 || bus_addr !== 32'h11223344 || bus_wdata !== 32'h55667788) begin
      errors++; $display("FAIL sel_rise got sel=%b addr=%h wdata=%h exp 1 11223344 55667788", bus_sel, bus_addr, bus_wdata);
    end
    reset = 1;
    @(negedge clk);
    checks++;
    if ({tx_valid, tx_data, bus_sel, bus_we, bus_addr, bus_wdata, busy, rx_ready} !== 77'h0) begin
      errors++; $display("FAIL reset_mid_bus got %h exp 0", {tx_valid, tx_data, bus_sel, bus_we, bus_addr, bus_wdata, busy, rx_ready});
    end
    reset = 0;
    build(8'h01, 32'h40, 32'h1234); model(8'h01, 32'h0, 2);
    run_frame(m_tx.size(), 2, 32'h0, 0);
    checks++;
    if (o_addr !== 32'h40 || o_wdata !== 32'h1234 || o_sel_cycles !== 3 || o_tx.size() != 1 || o_tx[0] !== 8'hA5) begin
      errors++; $display("FAIL post_reset_write got addr=%h wdata=%h sel=%0d exp 40 1234 3", o_addr, o_wdata, o_sel_cycles);
    end
  endtask

  task automatic test_random();
    logic [7:0] cmd;
    logic [31:0] addr, data, rdata;
    int wait_n, stall_n, sel;
    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 9);
      cmd = (sel == 0) ? 8'($urandom_range(3, 255)) : (sel < 5) ? 8'h01 : 8'h02;
      addr = $urandom; data = $urandom; rdata = $urandom;
      wait_n = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, 10);
      stall_n = $urandom_range(0, 3);
      build(cmd, addr, data); model(cmd, rdata, wait_n);
      run_frame(m_tx.size(), wait_n, rdata, stall_n);
      checks++;
      if (o_sel_cycles !== m_sel || o_tx.size() != m_tx.size() || !o_idle_after) begin
        errors++; $display("FAIL rand%0d_shape got sel=%0d len=%0d idle=%0d exp %0d %0d 1", n, o_sel_cycles, o_tx.size(), o_idle_after, m_sel, m_tx.size());
      end
      for (int i = 0; i < m_tx.size() && i < o_tx.size(); i++) begin
        checks++;
        if (o_tx[i] !== m_tx[i]) begin
          errors++; $display("FAIL rand%0d_byte%0d got %h exp %h", n, i, o_tx[i], m_tx[i]);
        end
      end
      if (m_sel > 0) begin
        checks++;
        if (o_addr !== addr || o_we !== (cmd == 8'h01) || (cmd == 8'h01 && o_wdata !== data) || !o_bus_stable || o_lat !== 1) begin
          errors++; $display("FAIL rand%0d_bus got addr=%h we=%b wdata=%h lat=%0d exp %h %b %h 1", n, o_addr, o_we, o_wdata, o_lat, addr, cmd == 8'h01, data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_bad_cmd();
    test_tx_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
